// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment receiver:
//   - segment bit positions (a = bit 6 down to g = bit 0) and one-hot masks
//   - the ten digit patterns and the blank pattern
//   - FSM state type and state constants (ARM, WAIT_CHANGE)
// ---------------------------------------------------------------------------
package seg7_pkg;

   // Segment bit positions on the 7-bit bus, active-high.
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [6:0] M_A = 7'(1 << SEG_A);
   localparam logic [6:0] M_B = 7'(1 << SEG_B);
   localparam logic [6:0] M_C = 7'(1 << SEG_C);
   localparam logic [6:0] M_D = 7'(1 << SEG_D);
   localparam logic [6:0] M_E = 7'(1 << SEG_E);
   localparam logic [6:0] M_F = 7'(1 << SEG_F);
   localparam logic [6:0] M_G = 7'(1 << SEG_G);

   // Digit patterns built from the lit segments.
   localparam logic [6:0] PAT_0     = M_A | M_B | M_C | M_D | M_E | M_F;
   localparam logic [6:0] PAT_1     = M_B | M_C;
   localparam logic [6:0] PAT_2     = M_A | M_B | M_D | M_E | M_G;
   localparam logic [6:0] PAT_3     = M_A | M_B | M_C | M_D | M_G;
   localparam logic [6:0] PAT_4     = M_B | M_C | M_F | M_G;
   localparam logic [6:0] PAT_5     = M_A | M_C | M_D | M_F | M_G;
   localparam logic [6:0] PAT_6     = M_A | M_C | M_D | M_E | M_F | M_G;
   localparam logic [6:0] PAT_7     = M_A | M_B | M_C;
   localparam logic [6:0] PAT_8     = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
   localparam logic [6:0] PAT_9     = M_A | M_B | M_C | M_D | M_F | M_G;
   localparam logic [6:0] PAT_BLANK = 7'b000_0000;

   // Qualification FSM.
   typedef logic [0:0] state_t;
   localparam state_t ST_ARM         = 1'b0;
   localparam state_t ST_WAIT_CHANGE = 1'b1;

endpackage : seg7_pkg

// File: rtl/seg7_pattern_dec.sv
// ---------------------------------------------------------------------------
// seg7_pattern_dec
// Combinational seven-segment pattern classifier.
// Ports:
//   pattern  [6:0] in   segment lines, bit6 = a ... bit0 = g
//   digit    [3:0] out  decoded digit (0 when not a digit)
//   is_digit       out  pattern is one of the ten digit patterns
//   is_blank       out  pattern is all segments off
// A pattern that is neither a digit nor blank is invalid.
// ---------------------------------------------------------------------------
module seg7_pattern_dec
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] digit,
   output logic       is_digit,
   output logic       is_blank
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      digit    = 4'd0;
      is_digit = 1'b1;
      is_blank = 1'b0;
      case (pattern)
         PAT_0: digit = 4'd0;
         PAT_1: digit = 4'd1;
         PAT_2: digit = 4'd2;
         PAT_3: digit = 4'd3;
         PAT_4: digit = 4'd4;
         PAT_5: digit = 4'd5;
         PAT_6: digit = 4'd6;
         PAT_7: digit = 4'd7;
         PAT_8: digit = 4'd8;
         PAT_9: digit = 4'd9;
         PAT_BLANK: begin
            is_digit = 1'b0;
            is_blank = 1'b1;
         end
         default: is_digit = 1'b0;
      endcase
   end

endmodule : seg7_pattern_dec

// File: rtl/seg7_to_bcd_rx.sv
// ---------------------------------------------------------------------------
// seg7_to_bcd_rx
// Debounced seven-segment to BCD receiver with a one-entry output buffer.
// A segment pattern must be sampled STABLE_CYCLES times in a row (legal
// range 2..15) before it is reported; each stable pattern is reported once.
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   seg_in    [6:0] in   segment lines, bit6 = a ... bit0 = g
//   bcd_out   [3:0] out  buffered digit, stable while out_valid = 1
//   out_valid       out  buffer holds an unconsumed digit
//   out_ready       in   consumer takes bcd_out when out_valid & out_ready
//   err             out  one-cycle pulse for a qualified invalid pattern
//   overrun         out  sticky: a qualified digit was dropped (rst clears)
//   err_cnt   [7:0] out  saturating count of err pulses; only present when
//                        the macro SEG7_RX_ERRCNT_EN is defined
// ---------------------------------------------------------------------------
module seg7_to_bcd_rx
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic [3:0] bcd_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err,
   output logic       overrun
`ifdef SEG7_RX_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
   localparam logic [3:0] CNT_QUAL = 4'(STABLE_CYCLES - 1);

   logic [6:0] seg_q,     seg_d;
   logic [3:0] stab_cnt_q, stab_cnt_d;
   state_t     state_q,   state_d;
   logic [3:0] bcd_q,     bcd_d;
   logic       valid_q,   valid_d;
   logic       err_q,     err_d;
   logic       overrun_q, overrun_d;

   logic       same;
   logic       qualify;
   logic [3:0] dec_digit;
   logic       dec_is_digit;
   logic       dec_is_blank;

   // The qualified pattern is the registered sample, not the live input.
   seg7_pattern_dec u_dec (
      .pattern  (seg_q),
      .digit    (dec_digit),
      .is_digit (dec_is_digit),
      .is_blank (dec_is_blank)
   );

   assign same    = (seg_in == seg_q);
   // stab_cnt counts repeats after the first sample, so S-1 means S samples.
   assign qualify = (state_q == ST_ARM) && (stab_cnt_q == CNT_QUAL);

   always_comb begin
      seg_d      = seg_in;
      stab_cnt_d = 4'd0;
      if (same) begin
         stab_cnt_d = (stab_cnt_q == CNT_MAX) ? CNT_MAX : stab_cnt_q + 4'd1;
      end

      state_d = state_q;
      case (state_q)
         ST_ARM: begin
            // If the input already moved on during the qualifying cycle,
            // stay armed so the next pattern is not lost.
            if (qualify && same) begin
               state_d = ST_WAIT_CHANGE;
            end
         end
         default: begin
            if (!same) begin
               state_d = ST_ARM;
            end
         end
      endcase
   end

   always_comb begin
      bcd_d     = bcd_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      err_d     = qualify && !dec_is_digit && !dec_is_blank;

      if (qualify && dec_is_digit) begin
         if (!valid_q || out_ready) begin
            // Empty buffer, or the old digit leaves on this same edge.
            bcd_d   = dec_digit;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q      <= 7'd0;
         stab_cnt_q <= 4'd0;
         state_q    <= ST_ARM;
         bcd_q      <= 4'd0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         // NOTE: registers take non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         seg_q      <= seg_d;
         stab_cnt_q <= stab_cnt_d;
         state_q    <= state_d;
         bcd_q      <= bcd_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bcd_out   = bcd_q;
   assign out_valid = valid_q;
   assign err       = err_q;
   assign overrun   = overrun_q;

`ifdef SEG7_RX_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counts on the same edge that raises err, so err_cnt moves with the pulse.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule : seg7_to_bcd_rx

// File: tb/tb_seg7_to_bcd_rx.sv
// ---------------------------------------------------------------------------
// tb_seg7_to_bcd_rx
// Self-checking bench for seg7_to_bcd_rx (STABLE_CYCLES = 4). A run-length
// model predicts the outputs every cycle; directed scenarios add literal
// expectations. Build with SEG7_RX_ERRCNT_EN defined to also check err_cnt.
// ---------------------------------------------------------------------------
module tb_seg7_to_bcd_rx;

   localparam int S = 4;

   localparam logic [6:0] P1    = 7'b0110000;
   localparam logic [6:0] P2    = 7'b1101101;
   localparam logic [6:0] P3    = 7'b1111001;
   localparam logic [6:0] P5    = 7'b1011011;
   localparam logic [6:0] P6    = 7'b1011111;
   localparam logic [6:0] P7    = 7'b1110000;
   localparam logic [6:0] P8    = 7'b1111111;
   localparam logic [6:0] P9    = 7'b1111011;
   localparam logic [6:0] PBAD  = 7'b1000001;
   localparam logic [6:0] BLANK = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_in;
   logic [3:0] bcd_out;
   logic       out_valid;
   logic       out_ready;
   logic       err;
   logic       overrun;
`ifdef SEG7_RX_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   seg7_to_bcd_rx #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .bcd_out   (bcd_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .overrun   (overrun)
`ifdef SEG7_RX_ERRCNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0] pat_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

   // 0..9 digit, 10 blank, 11 invalid
   function automatic int classify(input logic [6:0] p);
      if (p == 7'd0) return 10;
      for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
      return 11;
   endfunction

   logic [6:0] m_prev     = 7'd0;
   int         m_run      = 1;     // reset value of the sampler counts as one sample
   logic       m_pend     = 1'b0;  // a run reached S samples on the last edge
   logic [6:0] m_pend_pat = 7'd0;
   logic       m_valid    = 1'b0;
   logic [3:0] m_bcd      = 4'd0;
   logic       m_err      = 1'b0;
   logic       m_over     = 1'b0;
   int         m_errcnt   = 0;
   int         m_cls      = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_prev = 7'd0; m_run = 1; m_pend = 1'b0; m_pend_pat = 7'd0;
         m_valid = 1'b0; m_bcd = 4'd0; m_err = 1'b0; m_over = 1'b0; m_errcnt = 0;
      end else begin
         m_err = 1'b0;
         m_cls = m_pend ? classify(m_pend_pat) : 10;
         if (m_pend && m_cls < 10) begin
            if (!m_valid || out_ready) begin
               m_valid = 1'b1;
               m_bcd   = 4'(m_cls);
            end else begin
               m_over = 1'b1;
            end
         end else begin
            if (m_pend && m_cls == 11) begin
               m_err = 1'b1;
               if (m_errcnt < 255) m_errcnt++;
            end
            if (m_valid && out_ready) m_valid = 1'b0;
         end
         if (seg_in == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
         else                  m_run = 1;
         m_prev     = seg_in;
         m_pend     = (m_run == S);
         m_pend_pat = seg_in;
      end
   end

   // ---------------- per-cycle compare and monitor ----------------
   int         acc_q [$];
   int         err_seen = 0;

   always @(negedge clk) begin
      check("out_valid", out_valid, m_valid);
      check("err", err, m_err);
      check("overrun", overrun, m_over);
      if (m_valid) check("bcd_out", bcd_out, m_bcd);
`ifdef SEG7_RX_ERRCNT_EN
      check("err_cnt", err_cnt, m_errcnt);
`endif
      if (out_valid && out_ready) acc_q.push_back(int'(bcd_out));
      if (err) err_seen++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [6:0] s, input logic r);
      seg_in    = s;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input logic [6:0] s, input logic r, input int n);
      for (int i = 0; i < n; i++) step(s, r);
   endtask

   int exp_acc [6] = '{5, 3, 2, 6, 7, 9};

   initial begin
      rst = 1'b1; seg_in = BLANK; out_ready = 1'b0;
      #3;
      check("rst_bcd", bcd_out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_err", err, 0);
      check("rst_overrun", overrun, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      steps(BLANK, 1'b1, 6);

      // Basic decode: digit 5 appears on edge 5 for exactly one cycle.
      for (int k = 1; k <= 6; k++) begin
         step(P5, 1'b1);
         if (k == 4) check("basic_not_yet", out_valid, 0);
         if (k == 5) begin
            check("basic_valid", out_valid, 1);
            check("basic_bcd", bcd_out, 5);
         end
         if (k == 6) check("basic_one_cycle", out_valid, 0);
      end
      steps(BLANK, 1'b1, 6);

      // Glitch: 1 only held two samples, then 3 is stable.
      steps(P1, 1'b1, 2);
      for (int k = 1; k <= 6; k++) begin
         step(P3, 1'b1);
         if (k == 5) check("glitch_bcd", bcd_out, 3);
      end
      steps(BLANK, 1'b1, 6);

      // Invalid pattern.
      for (int k = 1; k <= 6; k++) begin
         step(PBAD, 1'b1);
         if (k == 5) check("invalid_err", err, 1);
         if (k == 6) check("invalid_err_pulse", err, 0);
         check("invalid_no_valid", out_valid, 0);
      end
`ifdef SEG7_RX_ERRCNT_EN
      check("invalid_err_cnt", err_cnt, 1);
`endif
      steps(BLANK, 1'b1, 6);

      // Simultaneous: digit 2 buffered, 6 qualifies on the handshake edge.
      steps(P2, 1'b0, 6);
      check("simul_old", bcd_out, 2);
      for (int k = 1; k <= 6; k++) begin
         step(P6, (k == 5));
         if (k == 5) begin
            check("simul_valid", out_valid, 1);
            check("simul_bcd", bcd_out, 6);
            check("simul_no_overrun", overrun, 0);
         end
      end
      steps(BLANK, 1'b1, 6);

      // Backpressure: 7 held, blank, then 8 dropped.
      steps(P7, 1'b0, 6);
      steps(BLANK, 1'b0, 6);
      for (int k = 1; k <= 6; k++) begin
         step(P8, 1'b0);
         if (k == 5) begin
            check("bp_keep_bcd", bcd_out, 7);
            check("bp_overrun", overrun, 1);
         end
      end
      steps(BLANK, 1'b1, 6);
      check("bp_overrun_sticky", overrun, 1);

      // Reset mid-qualification after stab_cnt reaches 2.
      steps(P9, 1'b1, 3);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_bcd", bcd_out, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_err", err, 0);
      #2 rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step(P9, 1'b1);
         if (k == 4) check("requal_not_yet", out_valid, 0);
         if (k == 5) begin
            check("requal_valid", out_valid, 1);
            check("requal_bcd", bcd_out, 9);
         end
      end
      steps(BLANK, 1'b1, 4);

      check("accepted_count", acc_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < acc_q.size()) check("accepted_digit", acc_q[i], exp_acc[i]);
      end
      check("err_pulses", err_seen, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seg7_to_bcd_rx
